multicyc_mem_resp: RTL and testbench
====================================

// Module: multicyc_mem_resp
// PURPOSE
//  Memory-side responder for the multicycle MIPS controller's memory interface.
//  Serves mem_rd/mem_wr requests with a fixed, parameterised wait-state latency
//  from one unified word-addressed array (instructions and data).
//  Signals completion with a one-cycle mem_ready pulse, so the MCU can stall in its
//  Fetch/MemRead/MemWrite states until ready is seen.
// PARAMETERS
//  ADDR_W       32   byte-address width
//  DEPTH_WORDS  256  number of 32-bit words in the array
//  WAIT_CYCLES  2    extra cycles between request accept and completion (0..15)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  addr       in   ADDR_W  byte address; must be held stable until mem_ready
//  wdata      in   32      write data; must be held stable until mem_ready
//  mem_rd     in   1       read request, level; held until mem_ready
//  mem_wr     in   1       write request, level; held until mem_ready
//  rdata      out  32      read data, registered; holds last successful read
//  mem_ready  out  1       one-cycle completion pulse
//  mem_err    out  1       high with mem_ready when the access was rejected
// BEHAVIOUR
//  Reset:
//   - state=IDLE, rdata=0, mem_ready=0, mem_err=0, wait counter=0.
//   - Array contents are not cleared.
//  FSM:
//   - IDLE: if mem_rd|mem_wr, latch addr, wdata and op, load cnt=WAIT_CYCLES.
//     Go to BUSY if WAIT_CYCLES>0, else to DONE.
//   - BUSY: cnt decrements each cycle. When cnt==1, go to DONE.
//   - DONE: perform the access; mem_ready=1 for this cycle only; next state IDLE.
//  Latency:
//   - Request first seen in IDLE at cycle t -> mem_ready at t+WAIT_CYCLES+1.
//   - rdata is valid in the same cycle as mem_ready.
//  Handshake:
//   - Requests are sampled only in IDLE, so there is at least one idle cycle
//     between transactions.
//   - Input changes during BUSY/DONE are ignored; latched values are used.
//  Access rules (word index = addr[ADDR_W-1:2]):
//   - Read: rdata <= mem[idx] at DONE.
//   - Write: mem[idx] <= wdata at DONE.
//  Errors (mem_err=1 with mem_ready; no array write; rdata unchanged):
//   - mem_rd and mem_wr both high at accept.
//   - addr[1:0] != 0 (misaligned).
//   - idx >= DEPTH_WORDS (out of range).
//  mem_err is 0 in every cycle where mem_ready is 0.
//  Reset mid-operation: in BUSY or DONE, return to IDLE next cycle.
//   - Pending write is dropped; mem_ready/mem_err are not asserted.
//  Back-to-back: controller holding mem_rd after ready starts a new transaction
//   from IDLE on the following cycle.
// CONFIGURATION
//  MEM_BYTE_EN_EN defined:
//   - Adds input be[3:0], latched at accept.
//   - Writes update only bytes whose be bit is 1.
//   - be=4'b0000 is a legal no-op write: ready=1, err=0.
//   - Sub-word writes still require addr[1:0]==0.
//   - Reads ignore be.
//  MEM_BYTE_EN_EN undefined:
//   - No be port; every write updates the full 32-bit word.
// TESTING
//  1. Read after reset, WAIT_CYCLES=2: mem[0]=32'hDEAD_BEEF preloaded,
//     mem_rd=1 addr=0 at t0 -> mem_ready=1 at t0+3, rdata=32'hDEAD_BEEF, err=0.
//  2. Write then read: wr addr=32'h10 wdata=32'h1234_5678, then rd addr=32'h10
//     -> second ready gives rdata=32'h1234_5678; latency 3 cycles each.
//  3. Errors, each -> ready=1 err=1, rdata unchanged, target word unchanged:
//     addr=32'h6 (misaligned); addr=32'h400 with DEPTH=256 (out of range);
//     rd and wr both high.
//  4. reset=1 in BUSY of a write to addr=32'h20 -> no ready pulse,
//     mem[8] unchanged, rdata=0, next request served normally.
//  5. WAIT_CYCLES=0: mem_rd held high continuously -> ready pulses every
//     2 cycles; inputs changed during DONE do not affect the current access.
//  6. MEM_BYTE_EN_EN: mem[1]=32'hAABBCCDD, wr addr=4 wdata=32'h11223344
//     be=4'b0101 -> read returns 32'hAA22CC44.

Source files
------------

// File: rtl/multicyc_mem_resp.sv
// Fixed-latency memory responder for the multicycle MIPS controller.
// Optional byte-enable writes: define MEM_BYTE_EN_EN.
module multicyc_mem_resp #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              mem_rd,
    input  logic              mem_wr,
`ifdef MEM_BYTE_EN_EN
    input  logic [3:0]        be,
`endif
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_rd;
    logic              l_wr;
    logic [3:0]        l_be;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] a_word;
    logic [31:0]       a_wdata;
    logic              a_rd;
    logic              a_wr;
    logic [3:0]        a_be;
    logic [IW-1:0]     a_idx;
    logic              a_err;
    logic              req;
    logic              enter_done;
    logic              do_wr;

    assign req = mem_rd | mem_wr;

    // Access operands: live inputs on a zero-wait accept, latched copy otherwise
    always_comb begin
        a_addr  = l_addr;
        a_wdata = l_wdata;
        a_rd    = l_rd;
        a_wr    = l_wr;
        a_be    = l_be;
        if (state == IDLE) begin
            a_addr  = addr;
            a_wdata = wdata;
            a_rd    = mem_rd;
            a_wr    = mem_wr;
`ifdef MEM_BYTE_EN_EN
            a_be    = be;
`else
            a_be    = 4'hF;
`endif
        end
        a_word = a_addr >> 2;
        a_idx  = a_addr[IW+1:2];
        a_err  = (a_rd & a_wr)
               | (a_addr[1:0] != 2'b00)
               | (a_word >= ADDR_W'(DEPTH_WORDS));
        enter_done = 1'b0;
        if (state == IDLE)
            enter_done = req && (WAIT_CYCLES == 0);
        else if (state == BUSY)
            enter_done = (cnt == 4'd1);
        do_wr = enter_done & a_wr & ~a_err & ~reset;
    end

    // Array write on entry to DONE; contents survive reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
`ifdef MEM_BYTE_EN_EN
            for (int b = 0; b < 4; b++)
                if (a_be[b])
                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
`else
            mem[a_idx] <= a_wdata;
`endif
        end
    end

    // Request FSM with registered ready/err pulse and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= 32'd0;
            l_rd      <= 1'b0;
            l_wr      <= 1'b0;
            l_be      <= 4'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        l_addr  <= a_addr;
                        l_wdata <= a_wdata;
                        l_rd    <= a_rd;
                        l_wr    <= a_wr;
                        l_be    <= a_be;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES > 0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_done) begin
                mem_ready <= 1'b1;
                mem_err   <= a_err;
                if (a_rd && !a_err)
                    rdata <= mem[a_idx];
            end
        end
    end

endmodule

// File: tb/tb_multicyc_mem_resp.sv
// Directed bench: u0 with two wait states, u1 with zero wait states.
// Byte-enable scenario runs only when MEM_BYTE_EN_EN is defined.
module tb_multicyc_mem_resp;

    logic        clk;
    logic        rst;
    logic [31:0] a0, d0, q0;
    logic        rd0, wr0, rdy0, err0;
    logic [31:0] a1, d1, q1;
    logic        rd1, wr1, rdy1, err1;
`ifdef MEM_BYTE_EN_EN
    logic [3:0]  be0;
    logic [3:0]  be1;
`endif

    int vec = 0;
    int bad = 0;

    multicyc_mem_resp #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(rst), .addr(a0), .wdata(d0),
        .mem_rd(rd0), .mem_wr(wr0),
`ifdef MEM_BYTE_EN_EN
        .be(be0),
`endif
        .rdata(q0), .mem_ready(rdy0), .mem_err(err0));

    multicyc_mem_resp #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(rst), .addr(a1), .wdata(d1),
        .mem_rd(rd1), .mem_wr(wr1),
`ifdef MEM_BYTE_EN_EN
        .be(be1),
`endif
        .rdata(q1), .mem_ready(rdy1), .mem_err(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic xact(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b,
                        output int lat, output logic err,
                        output logic [31:0] q, output logic tail);
        @(negedge clk);
        rd0 = rd; wr0 = wr; a0 = a; d0 = d;
`ifdef MEM_BYTE_EN_EN
        be0 = b;
`else
        if (b != 4'hF) $display("note: be ignored in this build");
`endif
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy0 && lat < 20);
        err = err0;
        q   = q0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = 32'h1; d0 = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        tail = rdy0 | err0;
    endtask

    task automatic xact1(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic err,
                         output logic [31:0] q);
        @(negedge clk);
        rd1 = rd; wr1 = wr; a1 = a; d1 = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy1 && lat < 20);
        err = err1;
        q   = q1;
        rd1 = 1'b0; wr1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vec++; if (q0 !== 32'd0) begin bad++;
            $display("FAIL rst_rdata got %h want 0", q0); end
        vec++; if (rdy0 !== 1'b0) begin bad++;
            $display("FAIL rst_ready got %b want 0", rdy0); end
        vec++; if (err0 !== 1'b0) begin bad++;
            $display("FAIL rst_err got %b want 0", err0); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_read_after_reset();
        int lat; logic e, t; logic [31:0] q;
        xact(0, 1, 32'h0, 32'hDEAD_BEEF, 4'hF, lat, e, q, t);
        vec++; if (lat !== 3 || e !== 1'b0) begin bad++;
            $display("FAIL preload_wr lat %0d err %b want 3 0", lat, e); end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        xact(1, 0, 32'h0, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (lat !== 3) begin bad++;
            $display("FAIL rd0_lat got %0d want 3", lat); end
        vec++; if (q !== 32'hDEAD_BEEF || e !== 1'b0) begin bad++;
            $display("FAIL rd0_data got %h err %b want deadbeef 0", q, e); end
        vec++; if (t !== 1'b0) begin bad++;
            $display("FAIL rd0_pulse got %b want 0 after ready", t); end
    endtask

    task automatic test_write_read();
        int lat; logic e, t; logic [31:0] q;
        xact(0, 1, 32'h10, 32'h1234_5678, 4'hF, lat, e, q, t);
        vec++; if (lat !== 3 || e !== 1'b0) begin bad++;
            $display("FAIL wr10 lat %0d err %b want 3 0", lat, e); end
        xact(1, 0, 32'h10, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (lat !== 3 || q !== 32'h1234_5678) begin bad++;
            $display("FAIL rd10 lat %0d data %h want 3 12345678", lat, q); end
    endtask

    task automatic test_errors();
        int lat; logic e, t; logic [31:0] q;
        xact(0, 1, 32'h4, 32'h0000_0004, 4'hF, lat, e, q, t);
        xact(1, 0, 32'h4, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (q !== 32'h4 || e !== 1'b0) begin bad++;
            $display("FAIL rd4 got %h err %b want 4 0", q, e); end
        xact(0, 1, 32'h6, 32'hFFFF_FFFF, 4'hF, lat, e, q, t);
        vec++; if (e !== 1'b1 || lat !== 3) begin bad++;
            $display("FAIL mis_wr err %b lat %0d want 1 3", e, lat); end
        xact(1, 0, 32'h6, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (e !== 1'b1 || q !== 32'h4) begin bad++;
            $display("FAIL mis_rd err %b data %h want 1 4", e, q); end
        vec++; if (t !== 1'b0) begin bad++;
            $display("FAIL err_pulse got %b want 0 after ready", t); end
        xact(1, 0, 32'h400, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (e !== 1'b1 || q !== 32'h4) begin bad++;
            $display("FAIL oor_rd err %b data %h want 1 4", e, q); end
        xact(0, 1, 32'h400, 32'h5555_5555, 4'hF, lat, e, q, t);
        vec++; if (e !== 1'b1) begin bad++;
            $display("FAIL oor_wr err %b want 1", e); end
        xact(1, 1, 32'h10, 32'hFFFF_0000, 4'hF, lat, e, q, t);
        vec++; if (e !== 1'b1 || q !== 32'h4) begin bad++;
            $display("FAIL rdwr err %b data %h want 1 4", e, q); end
        xact(1, 0, 32'h4, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (q !== 32'h4 || e !== 1'b0) begin bad++;
            $display("FAIL word1_kept got %h want 4", q); end
        xact(1, 0, 32'h10, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (q !== 32'h1234_5678) begin bad++;
            $display("FAIL word4_kept got %h want 12345678", q); end
        xact(1, 0, 32'h0, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (q !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL word0_kept got %h want deadbeef", q); end
    endtask

    task automatic test_reset_busy();
        int lat; int pulses; logic e, t; logic [31:0] q;
        xact(0, 1, 32'h20, 32'hCAFE_0000, 4'hF, lat, e, q, t);
        xact(1, 0, 32'h20, 32'h0, 4'hF, lat, e, q, t);
        @(negedge clk);
        wr0 = 1'b1; a0 = 32'h20; d0 = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wr0 = 1'b0;
        @(posedge clk); #1;
        pulses = int'(rdy0);
        @(negedge clk) rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            pulses += int'(rdy0);
        end
        vec++; if (pulses !== 0) begin bad++;
            $display("FAIL rstbusy_ready got %0d pulses want 0", pulses); end
        vec++; if (q0 !== 32'd0) begin bad++;
            $display("FAIL rstbusy_rdata got %h want 0", q0); end
        xact(1, 0, 32'h20, 32'h0, 4'hF, lat, e, q, t);
        vec++; if (lat !== 3 || q !== 32'hCAFE_0000) begin bad++;
            $display("FAIL rstbusy_word lat %0d got %h want 3 cafe0000", lat, q); end
    endtask

    task automatic test_back_to_back();
        int lat; logic e; logic [31:0] q;
        logic [5:0] pat;
        logic [31:0] r [6];
        xact1(0, 1, 32'hC, 32'h0000_AAAA, lat, e, q);
        vec++; if (lat !== 1 || e !== 1'b0) begin bad++;
            $display("FAIL w0_lat got %0d err %b want 1 0", lat, e); end
        xact1(0, 1, 32'h10, 32'h0000_BBBB, lat, e, q);
        @(negedge clk);
        rd1 = 1'b1; a1 = 32'hC;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = rdy1;
            r[i]   = q1;
            if (i == 0) begin
                a1 = 32'h10; wr1 = 1'b1; d1 = 32'h0000_DDDD;
            end
            if (i == 1) wr1 = 1'b0;
        end
        rd1 = 1'b0;
        vec++; if (pat !== 6'b010101) begin bad++;
            $display("FAIL b2b_ready got %b want 010101", pat); end
        vec++; if (r[0] !== 32'hAAAA || r[1] !== 32'hAAAA) begin bad++;
            $display("FAIL b2b_first got %h %h want aaaa", r[0], r[1]); end
        vec++; if (r[2] !== 32'hBBBB || r[4] !== 32'hBBBB) begin bad++;
            $display("FAIL b2b_next got %h %h want bbbb", r[2], r[4]); end
        @(posedge clk); #1;
    endtask

`ifdef MEM_BYTE_EN_EN
    task automatic test_byte_en();
        int lat; logic e, t; logic [31:0] q;
        xact(0, 1, 32'h4, 32'hAABB_CCDD, 4'hF, lat, e, q, t);
        xact(0, 1, 32'h4, 32'h1122_3344, 4'b0101, lat, e, q, t);
        vec++; if (lat !== 3 || e !== 1'b0) begin bad++;
            $display("FAIL be_wr lat %0d err %b want 3 0", lat, e); end
        xact(0, 1, 32'h4, 32'h9999_9999, 4'b0000, lat, e, q, t);
        vec++; if (lat !== 3 || e !== 1'b0) begin bad++;
            $display("FAIL be0_wr lat %0d err %b want 3 0", lat, e); end
        xact(1, 0, 32'h4, 32'h0, 4'b0000, lat, e, q, t);
        vec++; if (q !== 32'hAA22_CC44) begin bad++;
            $display("FAIL be_rd got %h want aa22cc44", q); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        a0 = '0; d0 = '0; rd0 = 1'b0; wr0 = 1'b0;
        a1 = '0; d1 = '0; rd1 = 1'b0; wr1 = 1'b0;
`ifdef MEM_BYTE_EN_EN
        be0 = 4'hF; be1 = 4'hF;
`endif
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_errors();
        test_reset_busy();
        test_back_to_back();
`ifdef MEM_BYTE_EN_EN
        test_byte_en();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
